// File: rtl/phase_countdown_timer.sv
// Phase countdown timer: loads duration*SCALER-1 ticks, counts down,
// supports pause/hold and emits a one-cycle expired pulse at phase end.
module phase_countdown_timer #(
  parameter int TICK_WIDTH = 32,
  parameter int SCALER     = 50000000,
  parameter int SEC_WIDTH  = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [SEC_WIDTH-1:0]  duration_seconds,
  input  logic                  pause,
  output logic [TICK_WIDTH-1:0] clock_ticks,
  output logic                  busy,
  output logic                  expired
);

  localparam int PW = SEC_WIDTH + TICK_WIDTH;
  localparam logic [PW-1:0] SCALE = PW'(SCALER);
  localparam logic [PW-1:0] MAXV =
    {{SEC_WIDTH{1'b0}}, {TICK_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED
  } state_t;

  state_t                  state, state_n;
  logic [TICK_WIDTH-1:0]   ticks_n;
  logic                    busy_n;
  logic                    expired_n;
  logic [PW-1:0]           product;
  logic [PW-1:0]           load_full;
  logic [TICK_WIDTH-1:0]   load_value;

  // Full-width product so large durations saturate instead of wrapping
  assign product    = PW'(duration_seconds) * SCALE;
  assign load_full  = product - PW'(1);
  assign load_value = (load_full > MAXV) ? '1
                    : load_full[TICK_WIDTH-1:0];

  always_comb begin
    state_n   = state;
    ticks_n   = clock_ticks;
    expired_n = 1'b0;
    if (load) begin
      if (duration_seconds != '0) begin
        state_n = pause ? PAUSED : RUNNING;
        ticks_n = load_value;
      end else begin
        state_n   = IDLE;
        ticks_n   = '0;
        expired_n = 1'b1;
      end
    end else begin
      case (state)
        IDLE: ticks_n = '0;
        RUNNING: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (clock_ticks != '0) begin
            ticks_n = clock_ticks - TICK_WIDTH'(1);
          end else begin
            state_n   = IDLE;
            expired_n = 1'b1;
          end
        end
        PAUSED: begin
          if (!pause) state_n = RUNNING;
        end
        default: begin
          state_n = IDLE;
          ticks_n = '0;
        end
      endcase
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clock_ticks <= '0;
      busy        <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state       <= state_n;
      clock_ticks <= ticks_n;
      busy        <= busy_n;
      expired     <= expired_n;
    end
  end

endmodule

// File: tb/tb_phase_countdown_timer.sv
// Scoreboard bench for phase_countdown_timer: small-SCALER instance
// checked every edge, full-SCALER instance for saturation and async reset.
module tb_phase_countdown_timer;

  localparam int TW = 32;
  localparam int SW = 7;
  localparam int S  = 4;
  localparam int SB = 50000000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b0;
  logic          load  = 1'b0;
  logic          pause = 1'b0;
  logic [SW-1:0] dur   = '0;
  logic [TW-1:0] ticks;
  logic          busy, expired;

  logic          reset_b = 1'b0;
  logic          load_b  = 1'b0;
  logic          pause_b = 1'b0;
  logic [SW-1:0] dur_b   = '0;
  logic [TW-1:0] ticks_b;
  logic          busy_b, expired_b;

  phase_countdown_timer #(
    .TICK_WIDTH(TW), .SCALER(S), .SEC_WIDTH(SW)
  ) dut (
    .clock(clock), .reset(reset), .load(load),
    .duration_seconds(dur), .pause(pause),
    .clock_ticks(ticks), .busy(busy), .expired(expired)
  );

  phase_countdown_timer #(
    .TICK_WIDTH(TW), .SCALER(SB), .SEC_WIDTH(SW)
  ) dut_big (
    .clock(clock), .reset(reset_b), .load(load_b),
    .duration_seconds(dur_b), .pause(pause_b),
    .clock_ticks(ticks_b), .busy(busy_b), .expired(expired_b)
  );

  typedef struct packed {
    logic [TW-1:0] t;
    logic          b;
    logic          e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int            m_st = 0;
  logic [TW-1:0] m_t  = '0;
  logic          m_b  = 1'b0;
  logic          m_e  = 1'b0;

  function automatic logic [TW-1:0] calc_l(input int unsigned d,
                                           input longint unsigned s);
    longint unsigned p;
    p = longint'(d) * s;
    p = p - 1;
    if (p > 64'h0000_0000_FFFF_FFFF) return '1;
    return p[TW-1:0];
  endfunction

  task automatic model_step(input logic ld, input logic [SW-1:0] d,
                            input logic p);
    if (ld) begin
      if (d != 0) begin
        m_t  = calc_l(d, S);
        m_st = p ? 2 : 1;
        m_b  = 1'b1;
        m_e  = 1'b0;
      end else begin
        m_st = 0;
        m_t  = '0;
        m_b  = 1'b0;
        m_e  = 1'b1;
      end
    end else begin
      m_e = 1'b0;
      case (m_st)
        1: begin
          if (p) m_st = 2;
          else if (m_t != 0) m_t = m_t - 1;
          else begin
            m_st = 0;
            m_b  = 1'b0;
            m_e  = 1'b1;
          end
        end
        2: if (!p) m_st = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic ld, input logic [SW-1:0] d,
                      input logic p);
    @(negedge clock);
    load  = ld;
    dur   = d;
    pause = p;
    model_step(ld, d, p);
    sb.push_back('{t: m_t, b: m_b, e: m_e});
    @(posedge clock);
    #2;
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({ticks, busy, expired} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got ticks=%0d busy=%b exp=%b want ticks=%0d busy=%b exp=%b",
                 $time, ticks, busy, expired, e.t, e.b, e.e);
      end
    end
  end

  task automatic test_reset;
    #1 reset = 1'b1;
    reset_b = 1'b1;
    #12;
    checks++;
    if ({ticks, busy, expired} !== '0) begin
      errors++;
      $display("FAIL reset got ticks=%0d busy=%b exp=%b want 0 0 0",
               ticks, busy, expired);
    end
    @(negedge clock);
    reset   = 1'b0;
    reset_b = 1'b0;
    m_st = 0; m_t = '0; m_b = 1'b0; m_e = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    n = 0;
    step(1'b1, 7'd3, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 7'd0, 1'b0);
      if (expired === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL basic_latency got %0d edges want 12", n);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_fall got %b want 0", busy);
    end
    step(1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 1'b0);
  endtask

  task automatic test_pause;
    int n;
    n = 0;
    step(1'b1, 7'd2, 1'b0);
    step(1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 7'd0, 1'b1);
      checks++;
      if (ticks !== 32'd5 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pause_hold got ticks=%0d busy=%b want 5 1",
                 ticks, busy);
      end
    end
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 7'd0, 1'b0);
      if (expired === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (2 + 11 + n != 20) begin
      errors++;
      $display("FAIL pause_latency got %0d edges want 20", 2 + 11 + n);
    end
  endtask

  task automatic test_reload;
    step(1'b1, 7'd1, 1'b0);
    step(1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 1'b0);
    step(1'b1, 7'd2, 1'b0);
    checks++;
    if (ticks !== 32'd7 || expired !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload got ticks=%0d exp=%b busy=%b want 7 0 1",
               ticks, expired, busy);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 7'd0, 1'b0);
  endtask

  task automatic test_zero_and_pause;
    step(1'b1, 7'd0, 1'b0);
    checks++;
    if (expired !== 1'b1 || busy !== 1'b0 || ticks !== '0) begin
      errors++;
      $display("FAIL zero_load got exp=%b busy=%b ticks=%0d want 1 0 0",
               expired, busy, ticks);
    end
    step(1'b0, 7'd0, 1'b0);
    checks++;
    if (expired !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse_width got exp=%b want 0", expired);
    end
    step(1'b1, 7'd1, 1'b1);
    checks++;
    if (ticks !== 32'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_paused got ticks=%0d busy=%b want 3 1",
               ticks, busy);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 7'd0, 1'b1);
    step(1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 1'b0);
    checks++;
    if (ticks !== 32'd2) begin
      errors++;
      $display("FAIL paused_release got ticks=%0d want 2", ticks);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 7'd0, 1'b0);
  endtask

  task automatic test_async_reset;
    @(negedge clock);
    load_b = 1'b1;
    dur_b  = 7'd5;
    @(negedge clock);
    load_b = 1'b0;
    checks++;
    if (ticks_b !== 32'd249999999 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL big_load got ticks=%0d busy=%b want 249999999 1",
               ticks_b, busy_b);
    end
    repeat (3) @(negedge clock);
    #2 reset_b = 1'b1;
    #1;
    checks++;
    if ({ticks_b, busy_b, expired_b} !== '0) begin
      errors++;
      $display("FAIL async_reset got ticks=%0d busy=%b exp=%b want 0 0 0",
               ticks_b, busy_b, expired_b);
    end
    #1 reset_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (expired_b !== 1'b0 || busy_b !== 1'b0) begin
        errors++;
        $display("FAIL post_reset got exp=%b busy=%b want 0 0",
                 expired_b, busy_b);
      end
    end
  endtask

  task automatic test_saturation;
    logic [SW-1:0] ds[3];
    logic [TW-1:0] want[3];
    ds   = '{7'd99, 7'd85, 7'd86};
    want = '{32'hFFFF_FFFF, 32'd4249999999, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      load_b = 1'b1;
      dur_b  = ds[i];
      @(negedge clock);
      load_b = 1'b0;
      checks++;
      if (ticks_b !== want[i]) begin
        errors++;
        $display("FAIL saturation d=%0d got %0d want %0d",
                 ds[i], ticks_b, want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_reload();
    test_zero_and_pause();
    test_async_reset();
    test_saturation();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
